montgomery_mm_param: RTL

- Parametrised radix-2 bit-serial Montgomery modular multiplier; next generation of the fixed 512-bit multiplier.
- Computes result = A·B·2^(-WIDTH) mod M with a guaranteed final conditional subtraction.
- Adds a busy/done handshake, operand validation (M odd) and a deterministic, data-independent latency.
- Sits between the host/AXI register block and the modular-exponentiation sequencer.

---
 rtl/montgomery_mm_param.sv | 98 +++++++++
 1 files changed

// File: rtl/montgomery_mm_param.sv
// Radix-2 bit-serial Montgomery multiplier: result = A*B*2^-WIDTH mod M.
// Fixed WIDTH+2 cycle latency, even-modulus rejection and busy/done handshake.
module montgomery_mm_param #(
  parameter int WIDTH = 512,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StLoop, StSub, StErr} state_t;

  state_t           state;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] opM;
  logic [WIDTH+1:0] accC;
  logic [WIDTH+1:0] accSum;
  logic [WIDTH-1:0] accDiff;
  logic [CNT_W-1:0] cnt;
  logic             aBit;
  logic             qBit;

  // opA is shifted right each iteration, so its LSB is always the current multiplier bit.
  always_comb begin
    aBit   = opA[0];
    qBit   = accC[0] ^ (aBit & opB[0]);
    accSum = accC;
    if (aBit) accSum = accSum + {2'b00, opB};
    if (qBit) accSum = accSum + {2'b00, opM};
    // Only used when C >= M, where C - M < M fits in WIDTH bits.
    accDiff = accC[WIDTH-1:0] - opM;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= StIdle;
      opA    <= '0;
      opB    <= '0;
      opM    <= '0;
      accC   <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            busy <= 1'b1;
            if (in_m[0]) begin
              opA   <= in_a;
              opB   <= in_b;
              opM   <= in_m;
              accC  <= '0;
              cnt   <= '0;
              state <= StLoop;
            end else begin
              state <= StErr;
            end
          end
        end
        StLoop: begin
          accC <= accSum >> 1;
          opA  <= opA >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= StSub;
        end
        StSub: begin
          result <= (accC >= {2'b00, opM}) ? accDiff : accC[WIDTH-1:0];
          err    <= 1'b0;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= StIdle;
        end
        StErr: begin
          result <= '0;
          err    <= 1'b1;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
